// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks, with a valid/ready word interface.
module serial_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  out_d, busy_d, done_d;
    logic                  bit_end;

    assign tx_ready = (state == IDLE);
    assign bit_end  = (cnt == CNT_LAST);

    // State, counters and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            shreg   <= shreg_d;
            tx_out  <= out_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

    // Next state; out_d is the line level for the cycle after this edge
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        out_d   = tx_out;
        busy_d  = tx_busy;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                out_d  = 1'b1;
                busy_d = 1'b0;
                if (tx_valid) begin
                    state_d = START;
                    shreg_d = tx_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    out_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    out_d   = shreg[0];
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx == IDX_LAST) begin
                        state_d = STOP;
                        out_d   = 1'b1;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        shreg_d = shreg >> 1;
                        out_d   = shreg_d[0];
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: 8-bit/4-clock instance plus a 4-bit/1-clock instance.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_out, a_busy, a_done;
    logic [3:0] b_data;
    logic       b_valid, b_ready, b_out, b_busy, b_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_prev = 0;
    int acc_last = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_out(a_out), .tx_busy(a_busy), .tx_done(a_done)
    );

    serial_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_out(b_out), .tx_busy(b_busy), .tx_done(b_done)
    );

    // Record cycle numbers of accept edges on instance A
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && a_valid && a_ready) begin
            acc_prev <= acc_last;
            acc_last <= cyc;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp;    // frame bits, first transmitted at bit 9
        bit         ignore; // drive 8'hFF with valid during the frame
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic accept_a(input logic [7:0] d);
        a_data  = d;
        a_valid = 1'b1;
        chk("ready_before_accept", 32'(a_ready), 32'd1);
        tick();
    endtask

    // Checks the 40 frame cycles and the done cycle; leaves A in its done cycle
    // with chain/chain_data applied to the inputs.
    task automatic frame_a(input logic [9:0] exp, input bit ignore,
                           input bit chain, input logic [7:0] chain_data);
        if (ignore) begin
            a_data  = 8'hFF;
            a_valid = 1'b1;
        end else begin
            a_valid = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("a_out_bit%0d_clk%0d", k, j), 32'(a_out), 32'(exp[9-k]));
                chk("a_busy_in_frame", 32'(a_busy), 32'd1);
                if (j == 0) begin
                    chk("a_ready_in_frame", 32'(a_ready), 32'd0);
                    chk("a_done_in_frame", 32'(a_done), 32'd0);
                end
                tick();
            end
        end
        chk("a_done_pulse", 32'(a_done), 32'd1);
        chk("a_ready_after", 32'(a_ready), 32'd1);
        chk("a_out_done_cycle", 32'(a_out), 32'd1);
        chk("a_busy_done_cycle", 32'(a_busy), 32'd0);
        a_valid = chain;
        a_data  = chain_data;
    endtask

    initial begin
        reset   = 1'b1;
        a_data  = 8'h5A;
        a_valid = 1'b1;
        b_data  = 4'hF;
        b_valid = 1'b1;

        vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[1] = '{8'hA5, 10'b0101001011, 1'b1};
        vecs[2] = '{8'h3C, 10'b0001111001, 1'b0};
        vecs[3] = '{8'h81, 10'b0100000011, 1'b1};

        // Reset held two cycles with valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out", 32'(a_out), 32'd1);
            chk("rst_busy", 32'(a_busy), 32'd0);
            chk("rst_done", 32'(a_done), 32'd0);
            chk("rst_ready", 32'(a_ready), 32'd1);
            chk("rst_b_busy", 32'(b_busy), 32'd0);
        end

        // First edge after reset release accepts immediately
        reset = 1'b0;
        b_valid = 1'b0;
        tick();
        chk("post_rst_accept_busy", 32'(a_busy), 32'd1);
        chk("post_rst_accept_out", 32'(a_out), 32'd0);
        frame_a(10'b0010110101, 1'b0, 1'b0, 8'h00);
        tick();

        // Idle hold with valid low
        for (int i = 0; i < 20; i++) begin
            chk("idle_out", 32'(a_out), 32'd1);
            chk("idle_busy_done_ready", {29'd0, a_busy, a_done, a_ready}, 32'd1);
            tick();
        end

        // Table-driven frames
        foreach (vecs[i]) begin
            accept_a(vecs[i].data);
            frame_a(vecs[i].exp, vecs[i].ignore, 1'b0, 8'h00);
            tick();
            chk("a_done_single", 32'(a_done), 32'd0);
            chk("a_out_idle_after", 32'(a_out), 32'd1);
        end

        // Back-to-back: 8'h00 then 8'hFF with valid held high
        accept_a(8'h00);
        frame_a(10'b0000000001, 1'b1, 1'b1, 8'hFF);
        tick();
        chk("b2b_period", 32'(acc_last - acc_prev), 32'd41);
        frame_a(10'b0111111111, 1'b0, 1'b0, 8'h00);
        tick();

        // Reset during data bit 3 of 8'h34 (bit 3 = 0)
        accept_a(8'h34);
        a_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("mid_bit3_out", 32'(a_out), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out", 32'(a_out), 32'd1);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_ready", 32'(a_ready), 32'd1);
        begin
            int dn = 0;
            for (int i = 0; i < 50; i++) begin
                if (a_done) dn++;
                tick();
            end
            chk("mid_rst_no_done", 32'(dn), 32'd0);
        end
        accept_a(8'h81);
        frame_a(10'b0100000011, 1'b0, 1'b0, 8'h00);
        tick();

        // CLKS_PER_BIT=1, DATA_WIDTH=4: 4'b1001
        begin
            logic [5:0] bexp;
            bexp = 6'b010011;
            b_data  = 4'b1001;
            b_valid = 1'b1;
            chk("b_ready_before", 32'(b_ready), 32'd1);
            tick();
            b_valid = 1'b0;
            b_data  = 4'b0110;
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("b_out_bit%0d", k), 32'(b_out), 32'(bexp[5-k]));
                chk("b_busy", 32'(b_busy), 32'd1);
                chk("b_done_early", 32'(b_done), 32'd0);
                tick();
            end
            chk("b_done_cycle7", 32'(b_done), 32'd1);
            chk("b_out_cycle7", 32'(b_out), 32'd1);
            chk("b_ready_cycle7", 32'(b_ready), 32'd1);
            tick();
            chk("b_done_cleared", 32'(b_done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the number of data bits per frame (legal range 1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4, SHALL set the number of clk cycles per transmitted bit (legal range 1..65535).
REQ-003 clk  input  1  SHALL be the sole clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 tx_data  input  DATA_WIDTH  SHALL carry the parallel word to send, sampled only at acceptance.
REQ-006 tx_valid  input  1  SHALL indicate that tx_data holds a word to send.
REQ-007 tx_ready  output  1  SHALL be high when the block can accept a word (state IDLE).
REQ-008 tx_out  output  1  SHALL be the registered serial line, idle high.
REQ-009 tx_busy  output  1  SHALL be high whenever a frame is in progress (states START, DATA, STOP).
REQ-010 tx_done  output  1  SHALL be a registered one-cycle pulse marking frame completion.

Function
REQ-011 The frame SHALL be one start bit (0), then DATA_WIDTH data bits LSB first, then one stop bit (1); each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP, with the following transitions:
- IDLE->START on accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after DATA_WIDTH bit periods.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 Accept SHALL occur at a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be copied into an internal shift register at that edge.
REQ-014 tx_ready SHALL be a combinational decode of state==IDLE and SHALL NOT depend on tx_valid.
REQ-015 Latency: tx_out SHALL go to 0 in the cycle after the accept edge, and tx_busy SHALL rise in that same cycle.
REQ-016 Changes to tx_data or tx_valid while tx_busy=1 SHALL be ignored, with no effect on the frame in flight.
REQ-017 A bit-period counter SHALL count 0..CLKS_PER_BIT-1; a bit-index counter SHALL count 0..DATA_WIDTH-1; both SHALL be sized with $clog2 and SHALL never exceed their terminal values.
REQ-018 At the edge ending the last stop-bit cycle, the state SHALL become IDLE and tx_done SHALL be 1 for exactly that following cycle; tx_out SHALL remain 1.
REQ-019 Back-to-back: if tx_valid=1 in the cycle tx_done=1, the next word SHALL be accepted at that edge; the minimum accept-to-accept period SHALL therefore be (DATA_WIDTH+2)*CLKS_PER_BIT+1 cycles.
REQ-020 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle, with no skipped or duplicated bits.
REQ-021 tx_valid=0 in IDLE SHALL hold all outputs at their idle values indefinitely.

Reset
REQ-022 With reset=1 at a rising edge, the block SHALL enter the following state after that edge, overriding any other input:
- state=IDLE, tx_out=1, tx_busy=0, tx_done=0, tx_ready=1.
- Both counters cleared and the shift register cleared.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no tx_done pulse.
REQ-024 A word presented with tx_valid=1 during a reset cycle SHALL NOT be accepted.
REQ-025 After reset deasserts, the first accept SHALL be possible at the first following edge.

Verification
REQ-026 Reset: hold reset=1 for 2 cycles with tx_valid=1 -> tx_out=1, tx_busy=0, tx_done=0, tx_ready=1, and no frame starts.
REQ-027 Single frame (DATA_WIDTH=8, CLKS_PER_BIT=4): send 8'hA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 cycles (40 cycles total); then tx_done pulses once and tx_ready=1.
REQ-028 Busy ignore: during the 8'hA5 frame, drive tx_data=8'hFF with tx_valid=1 -> the transmitted bits remain those of 8'hA5.
REQ-029 Back-to-back: send 8'h00 then 8'hFF with tx_valid held high -> accepts are exactly 41 cycles apart and there is no idle-high gap beyond the 1-cycle IDLE.
REQ-030 Reset mid-frame: assert reset during data bit 3 -> tx_out=1 the next cycle, tx_busy=0, tx_done never pulses, and the next frame is correct.
REQ-031 CLKS_PER_BIT=1, DATA_WIDTH=4: send 4'b1001 -> tx_out sequence 0,1,0,0,1,1, one cycle each, and tx_done pulses in cycle 7 after the accept edge.
